branch_redirect_unit: RTL and testbench
=======================================

# branch_redirect_unit

Parametrised branch-resolution and fetch-redirect unit for the superscalar core; successor to the two-lane PC correction logic. Resolves up to `LANES` branches per cycle in the memory stage, catches mispredictions in both directions (predicted not-taken but taken, and predicted taken but not-taken), and selects the oldest mispredicting lane. It issues one registered redirect to fetch under a valid/ready handshake, squashes younger lanes, pulses a pipeline flush, sends registered update packets to the predictor, and keeps saturating branch and mispredict counters.

## Interface
- `LANES`, default 2: resolution lanes. Lane 0 is the oldest.
- `PC_W`, default 9: PC width.
- `CNT_W`, default 16: statistics counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `res_valid` in LANES: lane holds a resolved instruction.
- `res_is_branch` in LANES: instruction is a conditional branch.
- `res_pred` in LANES: predicted taken.
- `res_taken` in LANES: actual outcome, taken.
- `res_pc_plus1` in LANES*PC_W: fall-through PC. Lane i occupies bits [i*PC_W +: PC_W].
- `res_target` in LANES*PC_W: branch target, packed the same way.
- `kill` out LANES: combinational; marks lanes younger than the selected mispredict.
- `redirect_valid` out 1: redirect pending to fetch.
- `redirect_pc` out PC_W: corrected PC.
- `redirect_ready` in 1: fetch accepts the redirect.
- `flush` out 1: one-cycle pulse that flushes IF/ID/EX.
- `upd_valid` out LANES: registered predictor-update strobes.
- `upd_taken` out LANES: registered actual outcomes.
- `upd_pc` out LANES*PC_W: registered branch PC (pc_plus1 − 1, mod 2^PC_W).
- `branch_cnt` out CNT_W: branches resolved.
- `mispred_cnt` out CNT_W: mispredictions.

## Operation
- Effective branch, lane i: `eb[i] = res_valid[i] & res_is_branch[i] & ~kill[i] & accept`.
- `accept = ~redirect_valid`. While a redirect is pending, every lane is wrong-path and is ignored.
- Mispredict, lane i: `mp[i] = eb[i] & (res_taken[i] ^ res_pred[i])`.
- Selected lane `s` is the lowest i with `mp[i]`.
- `kill[j] = 1` for every j > s. `kill` is all-zero when no lane mispredicts or when `accept = 0`. Killed lanes produce no update and are not counted.
- Corrected PC for lane s is `res_taken[s] ? res_target[s] : res_pc_plus1[s]`.
- State machine:
  - IDLE: `redirect_valid = 0`. Any `mp` → PEND, latching `redirect_pc` and asserting `flush` for the next cycle.
  - PEND: `redirect_valid = 1`. `redirect_pc` is held stable. `redirect_ready = 1` → IDLE.
- A new mispredict cannot be captured in the cycle the handshake completes, because `accept` is still 0. It is captured from the following cycle.
- Predictor update: `upd_valid[i] <= eb[i]`. `upd_taken` and `upd_pc` are registered in the same cycle. Correctly predicted branches are also updated.
- Counters:
  - `branch_cnt += popcount(eb)`.
  - `mispred_cnt += |mp`, so at most 1 per cycle.
  - Both saturate at 2^CNT_W − 1 and never wrap.
- PC arithmetic is modulo 2^PC_W with no carry out.

## Timing
- Reset values: `redirect_valid` 0, `redirect_pc` 0, `flush` 0, `upd_*` 0, both counters 0, state IDLE. `kill` follows its combinational equation.
- Reset deasserted mid-PEND: the pending redirect is dropped and the state is IDLE.
- Latency:
  - Mispredict on inputs in cycle N: `redirect_valid` and `flush` high in N+1.
  - `flush` is high for exactly one cycle, even if `redirect_ready` stays low.
  - `upd_*` appears in N+1.
  - Counters update at the N→N+1 edge.
- Handshake: transfer happens on a cycle where `redirect_valid & redirect_ready` is true. The next cycle has `redirect_valid = 0`. `redirect_ready` while IDLE has no effect.
- Both lanes mispredicting in the same cycle: lane 0 wins and lane 1 is killed.

## Test plan
1. Lane 0: pred=0, taken=1, target=0x040. Lane 1 invalid. → N+1: `redirect_valid=1`, `redirect_pc=0x040`, `flush=1` for 1 cycle; `mispred_cnt=1`, `branch_cnt=1`.
2. Lane 1: pred=1, taken=0, pc_plus1=0x011, with `redirect_ready` held 0 for 3 cycles. → `redirect_pc=0x011` held stable for 4 cycles; drops the cycle after ready=1.
3. Both lanes mispredict (lane 0 target 0x100, lane 1 target 0x020). → `kill=2'b10`, `redirect_pc=0x100`, `mispred_cnt +1`, `upd_valid=2'b01`.
4. Both lanes correctly predicted branches, pc_plus1 0x005 and 0x006. → no redirect; `upd_valid=2'b11`, `upd_pc` 0x004 and 0x005; `branch_cnt +2`.
5. Mispredict presented while PEND. → ignored; no counter change, `upd_valid=0`. Also preload `branch_cnt` to 0xFFFF with a branch present → counter stays 0xFFFF.
6. Assert `rst` low during PEND. → all outputs go to reset values immediately, before the next clock edge. After release the unit accepts a new mispredict normally.

Source files
------------

// File: rtl/branch_redirect_unit_if.sv
// Signal bundle between the branch resolution lanes, fetch redirect path and predictor update.
// The master side is the redirect unit; the slave side is the surrounding pipeline.
interface branch_redirect_unit_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned PC_W  = 9,
  parameter int unsigned CNT_W = 16
) ();
  logic [LANES-1:0]      res_valid;
  logic [LANES-1:0]      res_is_branch;
  logic [LANES-1:0]      res_pred;
  logic [LANES-1:0]      res_taken;
  logic [LANES*PC_W-1:0] res_pc_plus1;
  logic [LANES*PC_W-1:0] res_target;
  logic [LANES-1:0]      kill;
  logic                  redirect_valid;
  logic [PC_W-1:0]       redirect_pc;
  logic                  redirect_ready;
  logic                  flush;
  logic [LANES-1:0]      upd_valid;
  logic [LANES-1:0]      upd_taken;
  logic [LANES*PC_W-1:0] upd_pc;
  logic [CNT_W-1:0]      branch_cnt;
  logic [CNT_W-1:0]      mispred_cnt;

  modport master (
    input  res_valid, res_is_branch, res_pred, res_taken, res_pc_plus1, res_target,
    input  redirect_ready,
    output kill, redirect_valid, redirect_pc, flush,
    output upd_valid, upd_taken, upd_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    output res_valid, res_is_branch, res_pred, res_taken, res_pc_plus1, res_target,
    output redirect_ready,
    input  kill, redirect_valid, redirect_pc, flush,
    input  upd_valid, upd_taken, upd_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Resolves up to LANES branches per cycle, redirects fetch on the oldest mispredict,
// kills younger lanes, pulses flush, updates the predictor and keeps saturating statistics.
module branch_redirect_unit #(
  parameter int unsigned LANES = 2,
  parameter int unsigned PC_W  = 9,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_redirect_unit_if.master bus
);

  typedef enum logic {StIdle, StPend} state_e;

  state_e                state_q, state_d;
  logic [PC_W-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  flush_q, flush_d;
  logic [LANES-1:0]      upd_valid_q, upd_taken_q;
  logic [LANES*PC_W-1:0] upd_pc_q, upd_pc_d;
  logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]      mispred_cnt_q, mispred_cnt_d;

  logic                  accept;
  logic [LANES-1:0]      cand, mp_raw, kill, eb, mp;
  logic                  found;
  logic [PC_W-1:0]       corr_pc;
  logic [CNT_W:0]        br_sum;

  assign accept = (state_q == StIdle);

  // Oldest mispredicting lane wins; every lane after it is wrong-path.
  always_comb begin
    found   = 1'b0;
    corr_pc = '0;
    kill    = '0;
    cand    = bus.res_valid & bus.res_is_branch & {LANES{accept}};
    mp_raw  = cand & (bus.res_taken ^ bus.res_pred);
    for (int i = 0; i < LANES; i++) begin
      if (found) begin
        kill[i] = 1'b1;
      end else if (mp_raw[i]) begin
        found   = 1'b1;
        corr_pc = bus.res_taken[i] ? bus.res_target[i*PC_W +: PC_W]
                                   : bus.res_pc_plus1[i*PC_W +: PC_W];
      end
    end
    eb = cand & ~kill;
    mp = mp_raw & ~kill;
  end

  always_comb begin
    upd_pc_d = '0;
    for (int i = 0; i < LANES; i++) begin
      upd_pc_d[i*PC_W +: PC_W] = bus.res_pc_plus1[i*PC_W +: PC_W] - PC_W'(1);
    end
  end

  // One extra bit catches the carry so the counter clamps instead of wrapping.
  always_comb begin
    br_sum = {1'b0, branch_cnt_q};
    for (int i = 0; i < LANES; i++) begin
      br_sum = br_sum + {{CNT_W{1'b0}}, eb[i]};
    end
    branch_cnt_d  = br_sum[CNT_W] ? {CNT_W{1'b1}} : br_sum[CNT_W-1:0];
    mispred_cnt_d = mispred_cnt_q;
    if (|mp && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StPend;
          redirect_pc_d = corr_pc;
          flush_d       = 1'b1;
        end
      end
      StPend: begin
        if (bus.redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      upd_valid_q   <= '0;
      upd_taken_q   <= '0;
      upd_pc_q      <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      upd_valid_q   <= eb;
      upd_taken_q   <= bus.res_taken & eb;
      upd_pc_q      <= upd_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.kill           = kill;
  assign bus.redirect_valid = (state_q == StPend);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: inputs change after a rising edge, registered
// outputs are checked 1 ns after the next rising edge, kill just after the inputs settle.
module tb_branch_redirect_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  branch_redirect_unit_if #(.LANES(2), .PC_W(9), .CNT_W(16)) bus ();

  branch_redirect_unit #(
    .LANES(2),
    .PC_W (9),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] br, input logic [1:0] pr,
                       input logic [1:0] tk, input logic [8:0] p0, input logic [8:0] p1,
                       input logic [8:0] t0, input logic [8:0] t1);
    bus.res_valid     = v;
    bus.res_is_branch = br;
    bus.res_pred      = pr;
    bus.res_taken     = tk;
    bus.res_pc_plus1  = {p1, p0};
    bus.res_target    = {t1, t0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.redirect_ready = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    #1 rst = 1'b0;
    #2;
    check("rst_rv", 32'(bus.redirect_valid), 32'h0);
    check("rst_pc", 32'(bus.redirect_pc), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_upd_valid", 32'(bus.upd_valid), 32'h0);
    check("rst_upd_pc", 32'(bus.upd_pc), 32'h0);
    check("rst_bcnt", 32'(bus.branch_cnt), 32'h0);
    check("rst_mcnt", 32'(bus.mispred_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: lane 0 predicted not-taken, actually taken
    tick();
    drive(2'b01, 2'b01, 2'b00, 2'b01, 9'h001, 9'h000, 9'h040, 9'h000);
    #1 check("t1_kill", 32'(bus.kill), 32'h2);
    tick();
    check("t1_rv", 32'(bus.redirect_valid), 32'h1);
    check("t1_pc", 32'(bus.redirect_pc), 32'h040);
    check("t1_flush", 32'(bus.flush), 32'h1);
    check("t1_mcnt", 32'(bus.mispred_cnt), 32'h1);
    check("t1_bcnt", 32'(bus.branch_cnt), 32'h1);
    check("t1_upd_valid", 32'(bus.upd_valid), 32'h1);
    check("t1_upd_taken", 32'(bus.upd_taken), 32'h1);
    check("t1_upd_pc0", 32'(bus.upd_pc[8:0]), 32'h000);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    bus.redirect_ready = 1'b1;
    tick();
    check("t1_rv_done", 32'(bus.redirect_valid), 32'h0);
    check("t1_flush_done", 32'(bus.flush), 32'h0);
    check("t1_upd_idle", 32'(bus.upd_valid), 32'h0);
    bus.redirect_ready = 1'b0;

    // 2: lane 1 predicted taken, not taken; fetch stalls 3 cycles
    drive(2'b10, 2'b10, 2'b10, 2'b00, 9'h000, 9'h011, 9'h000, 9'h0AA);
    #1 check("t2_kill", 32'(bus.kill), 32'h0);
    tick();
    check("t2_rv", 32'(bus.redirect_valid), 32'h1);
    check("t2_pc", 32'(bus.redirect_pc), 32'h011);
    check("t2_flush", 32'(bus.flush), 32'h1);
    check("t2_mcnt", 32'(bus.mispred_cnt), 32'h2);
    check("t2_bcnt", 32'(bus.branch_cnt), 32'h2);
    check("t2_upd_valid", 32'(bus.upd_valid), 32'h2);
    check("t2_upd_pc1", 32'(bus.upd_pc[17:9]), 32'h010);

    // 5: a wrong-path mispredict presented while pending must be ignored
    drive(2'b01, 2'b01, 2'b00, 2'b01, 9'h002, 9'h000, 9'h155, 9'h000);
    #1 check("t5_kill_pend", 32'(bus.kill), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_rv_hold", 32'(bus.redirect_valid), 32'h1);
      check("t2_pc_hold", 32'(bus.redirect_pc), 32'h011);
      check("t2_flush_low", 32'(bus.flush), 32'h0);
      check("t5_mcnt_hold", 32'(bus.mispred_cnt), 32'h2);
      check("t5_bcnt_hold", 32'(bus.branch_cnt), 32'h2);
      check("t5_upd_none", 32'(bus.upd_valid), 32'h0);
    end
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    check("t2_rv_drop", 32'(bus.redirect_valid), 32'h0);
    check("t5_mcnt_hs", 32'(bus.mispred_cnt), 32'h2);
    check("t5_upd_hs", 32'(bus.upd_valid), 32'h0);
    #1 check("t5_kill_idle", 32'(bus.kill), 32'h2);
    tick();
    check("t5_rv_capture", 32'(bus.redirect_valid), 32'h1);
    check("t5_pc_capture", 32'(bus.redirect_pc), 32'h155);
    check("t5_mcnt_capture", 32'(bus.mispred_cnt), 32'h3);
    check("t5_bcnt_capture", 32'(bus.branch_cnt), 32'h3);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // 3: both lanes mispredict, lane 0 wins
    drive(2'b11, 2'b11, 2'b00, 2'b11, 9'h001, 9'h002, 9'h100, 9'h020);
    #1 check("t3_kill", 32'(bus.kill), 32'h2);
    tick();
    check("t3_rv", 32'(bus.redirect_valid), 32'h1);
    check("t3_pc", 32'(bus.redirect_pc), 32'h100);
    check("t3_mcnt", 32'(bus.mispred_cnt), 32'h4);
    check("t3_bcnt", 32'(bus.branch_cnt), 32'h4);
    check("t3_upd_valid", 32'(bus.upd_valid), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // 4: both lanes correctly predicted
    drive(2'b11, 2'b11, 2'b01, 2'b01, 9'h005, 9'h006, 9'h0F0, 9'h033);
    #1 check("t4_kill", 32'(bus.kill), 32'h0);
    tick();
    check("t4_rv", 32'(bus.redirect_valid), 32'h0);
    check("t4_flush", 32'(bus.flush), 32'h0);
    check("t4_upd_valid", 32'(bus.upd_valid), 32'h3);
    check("t4_upd_taken", 32'(bus.upd_taken), 32'h1);
    check("t4_upd_pc", 32'(bus.upd_pc), {14'h0, 9'h005, 9'h004});
    check("t4_bcnt", 32'(bus.branch_cnt), 32'h6);
    check("t4_mcnt", 32'(bus.mispred_cnt), 32'h4);

    // PC wrap on update: pc_plus1 0 gives 0x1FF; lane 1 is not a branch
    drive(2'b11, 2'b01, 2'b00, 2'b00, 9'h000, 9'h009, 9'h000, 9'h000);
    tick();
    check("wrap_upd_pc0", 32'(bus.upd_pc[8:0]), 32'h1FF);
    check("wrap_upd_valid", 32'(bus.upd_valid), 32'h1);
    check("wrap_bcnt", 32'(bus.branch_cnt), 32'h7);

    // 6: asynchronous reset during a pending redirect
    drive(2'b01, 2'b01, 2'b00, 2'b01, 9'h001, 9'h000, 9'h033, 9'h000);
    tick();
    check("t6_rv_pend", 32'(bus.redirect_valid), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    #1 rst = 1'b0;
    #1;
    check("t6_rv_rst", 32'(bus.redirect_valid), 32'h0);
    check("t6_pc_rst", 32'(bus.redirect_pc), 32'h0);
    check("t6_flush_rst", 32'(bus.flush), 32'h0);
    check("t6_upd_rst", 32'(bus.upd_valid), 32'h0);
    check("t6_bcnt_rst", 32'(bus.branch_cnt), 32'h0);
    check("t6_mcnt_rst", 32'(bus.mispred_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive(2'b11, 2'b11, 2'b11, 2'b01, 9'h010, 9'h077, 9'h0C0, 9'h0D0);
    #1 check("t6_kill_new", 32'(bus.kill), 32'h0);
    tick();
    check("t6_rv_new", 32'(bus.redirect_valid), 32'h1);
    check("t6_pc_new", 32'(bus.redirect_pc), 32'h077);
    check("t6_bcnt_new", 32'(bus.branch_cnt), 32'h2);
    check("t6_mcnt_new", 32'(bus.mispred_cnt), 32'h1);
    check("t6_upd_new", 32'(bus.upd_valid), 32'h3);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;

    // branch counter saturation: 2 correct branches per cycle from 2 up to 0xFFFE, then clamp
    drive(2'b11, 2'b11, 2'b00, 2'b00, 9'h021, 9'h022, 9'h000, 9'h000);
    for (int k = 0; k < 32766; k++) @(posedge clk);
    #1 check("sat_bcnt_pre", 32'(bus.branch_cnt), 32'hFFFE);
    tick();
    check("sat_bcnt_clamp", 32'(bus.branch_cnt), 32'hFFFF);
    tick();
    check("sat_bcnt_hold", 32'(bus.branch_cnt), 32'hFFFF);
    check("sat_mcnt", 32'(bus.mispred_cnt), 32'h1);
    check("sat_rv", 32'(bus.redirect_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
